// File: rtl/spad_prefetch_arbiter.sv
// Ping-pong scratchpad fill arbiter: streams NUM_MAT matrices from the MIG read
// channel into one bank while the controller owns the other through a registered mux.

module spad_bram_lane #(
  parameter int AW = 10,
  parameter int DW = 1024
) (
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic          fill,
  input  logic          fill_we,
  input  logic [AW-1:0] fill_addr,
  input  logic [DW-1:0] fill_din,
  input  logic          ctl_we,
  input  logic [AW-1:0] ctl_addr,
  input  logic [DW-1:0] ctl_din,
  output logic          we,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] din
);
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      we   <= 1'b0;
      addr <= '0;
      din  <= '0;
    end else if (fill) begin
      we   <= fill_we;
      addr <= fill_addr;
      din  <= fill_din;
    end else begin
      we   <= ctl_we;
      addr <= ctl_addr;
      din  <= ctl_din;
    end
  end
endmodule

module spad_prefetch_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 1024,
  parameter int REG_WIDTH  = 32,
  parameter int NUM_MAT    = 2,
  parameter int MAX_BURST  = 256,
  parameter int BANK_DEPTH = 1024,
  parameter int BANK_AW    = $clog2(BANK_DEPTH)
) (
  input  logic                            clk_i,
  input  logic                            rst_n,
  input  logic                            start_i,
  input  logic                            bank_sel_i,
  input  logic [NUM_MAT*ADDR_WIDTH-1:0]   mat_addr_i,
  input  logic [NUM_MAT*REG_WIDTH-1:0]    mat_len_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            err_o,
  output logic [ADDR_WIDTH-1:0]           mig_addr_o,
  output logic                            mig_arvalid_o,
  output logic [7:0]                      mig_arlen_o,
  input  logic                            mig_arready_i,
  input  logic [DATA_WIDTH-1:0]           mig_rdata_i,
  input  logic                            mig_rvalid_i,
  input  logic                            mig_rlast_i,
  output logic                            mig_rready_o,
  input  logic [NUM_MAT-1:0]              ctl_bram_we_i,
  input  logic [NUM_MAT*BANK_AW-1:0]      ctl_bram_addr_i,
  input  logic [NUM_MAT*DATA_WIDTH-1:0]   ctl_bram_din_i,
  output logic [2*NUM_MAT-1:0]            out_bram_we_o,
  output logic [2*NUM_MAT*BANK_AW-1:0]    out_bram_addr_o,
  output logic [2*NUM_MAT*DATA_WIDTH-1:0] out_bram_din_o
);
  localparam int MW = $clog2(NUM_MAT + 1);
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(MAX_BURST * (DATA_WIDTH / 8));

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_SEL   = 3'd2;
  localparam logic [2:0] S_REQ   = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]                           state;
  logic                                 sel_q;
  logic [NUM_MAT-1:0][ADDR_WIDTH-1:0]   base_q;
  logic [NUM_MAT-1:0][REG_WIDTH-1:0]    len_q;
  logic [MW-1:0]                        mat;
  logic [REG_WIDTH-1:0]                 rem;
  logic [ADDR_WIDTH-1:0]                addr_q;
  logic [BANK_AW:0]                     word;
  logic                                 err_q;
  logic                                 done_q;

  logic [REG_WIDTH-1:0]  cur_len;
  logic [ADDR_WIDTH-1:0] cur_base;
  logic                  any_bad;
  logic [8:0]            burst;
  logic [REG_WIDTH-1:0]  rem_nxt;
  logic                  beat;
  logic                  unused_word_msb;

  // The active matrix index runs one past the last matrix, so select with a compare loop.
  always_comb begin
    cur_len  = '0;
    cur_base = '0;
    any_bad  = 1'b0;
    for (int i = 0; i < NUM_MAT; i++) begin
      if (MW'(i) == mat) begin
        cur_len  = len_q[i];
        cur_base = base_q[i];
      end
      if (len_q[i] > REG_WIDTH'(BANK_DEPTH)) any_bad = 1'b1;
    end
  end

  assign burst           = (rem > REG_WIDTH'(MAX_BURST)) ? 9'(MAX_BURST) : rem[8:0];
  assign rem_nxt         = rem - REG_WIDTH'(1);
  assign beat            = (state == S_DATA) && mig_rvalid_i;
  assign unused_word_msb = word[BANK_AW];

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      sel_q  <= 1'b0;
      base_q <= '0;
      len_q  <= '0;
      mat    <= '0;
      rem    <= '0;
      addr_q <= '0;
      word   <= '0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: if (start_i) begin
          sel_q  <= bank_sel_i;
          base_q <= mat_addr_i;
          len_q  <= mat_len_i;
          err_q  <= 1'b0;
          state  <= S_CHECK;
        end
        S_CHECK: begin
          if (any_bad) begin
            err_q  <= 1'b1;
            done_q <= 1'b1;
            state  <= S_IDLE;
          end else begin
            mat   <= '0;
            state <= S_SEL;
          end
        end
        S_SEL: begin
          if (mat == MW'(NUM_MAT)) begin
            done_q <= 1'b1;
            state  <= S_DONE;
          end else if (cur_len == '0) begin
            mat <= mat + MW'(1);
          end else begin
            rem    <= cur_len;
            addr_q <= cur_base;
            word   <= '0;
            state  <= S_REQ;
          end
        end
        S_REQ: if (mig_arready_i) state <= S_DATA;
        S_DATA: if (mig_rvalid_i) begin
          word <= word + (BANK_AW+1)'(1);
          rem  <= rem_nxt;
          // rlast alone ends a burst; the beat count only decides whether another follows.
          if (mig_rlast_i) begin
            if (rem_nxt == '0) begin
              mat   <= mat + MW'(1);
              state <= S_SEL;
            end else begin
              addr_q <= addr_q + BURST_BYTES;
              state  <= S_REQ;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy_o        = (state != S_IDLE);
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign mig_arvalid_o = (state == S_REQ);
  assign mig_addr_o    = mig_arvalid_o ? addr_q : '0;
  assign mig_arlen_o   = mig_arvalid_o ? 8'(burst - 9'd1) : 8'd0;
  assign mig_rready_o  = (state == S_DATA);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    for (genvar m = 0; m < NUM_MAT; m++) begin : g_mat
      spad_bram_lane #(.AW(BANK_AW), .DW(DATA_WIDTH)) u_lane (
        .clk_i    (clk_i),
        .rst_n    (rst_n),
        .fill     (busy_o && (sel_q == 1'(b))),
        .fill_we  (beat && (mat == MW'(m))),
        .fill_addr(word[BANK_AW-1:0]),
        .fill_din (mig_rdata_i),
        .ctl_we   (ctl_bram_we_i[m]),
        .ctl_addr (ctl_bram_addr_i[m*BANK_AW +: BANK_AW]),
        .ctl_din  (ctl_bram_din_i[m*DATA_WIDTH +: DATA_WIDTH]),
        .we       (out_bram_we_o[b*NUM_MAT+m]),
        .addr     (out_bram_addr_o[(b*NUM_MAT+m)*BANK_AW +: BANK_AW]),
        .din      (out_bram_din_o[(b*NUM_MAT+m)*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  end
endmodule

// File: tb/tb_spad_prefetch_arbiter.sv
// Directed bench: MIG responder driven inline, BRAM writes checked against a scoreboard queue.

module tb_spad_prefetch_arbiter;
  localparam int AW = 32;
  localparam int DW = 1024;
  localparam int BW = 10;

  logic            clk_i = 1'b0;
  logic            rst_n;
  logic            start_i;
  logic            bank_sel_i;
  logic [2*AW-1:0] mat_addr_i;
  logic [63:0]     mat_len_i;
  logic            busy_o, done_o, err_o;
  logic [AW-1:0]   mig_addr_o;
  logic            mig_arvalid_o;
  logic [7:0]      mig_arlen_o;
  logic            mig_arready_i;
  logic [DW-1:0]   mig_rdata_i;
  logic            mig_rvalid_i, mig_rlast_i, mig_rready_o;
  logic [1:0]      ctl_bram_we_i;
  logic [2*BW-1:0] ctl_bram_addr_i;
  logic [2*DW-1:0] ctl_bram_din_i;
  logic [3:0]      out_bram_we_o;
  logic [4*BW-1:0] out_bram_addr_o;
  logic [4*DW-1:0] out_bram_din_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int            idx;
    logic [BW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
  wr_t exp_q[$];

  spad_prefetch_arbiter dut (
    .clk_i(clk_i), .rst_n(rst_n), .start_i(start_i), .bank_sel_i(bank_sel_i),
    .mat_addr_i(mat_addr_i), .mat_len_i(mat_len_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .mig_addr_o(mig_addr_o), .mig_arvalid_o(mig_arvalid_o), .mig_arlen_o(mig_arlen_o),
    .mig_arready_i(mig_arready_i), .mig_rdata_i(mig_rdata_i), .mig_rvalid_i(mig_rvalid_i),
    .mig_rlast_i(mig_rlast_i), .mig_rready_o(mig_rready_o),
    .ctl_bram_we_i(ctl_bram_we_i), .ctl_bram_addr_i(ctl_bram_addr_i), .ctl_bram_din_i(ctl_bram_din_i),
    .out_bram_we_o(out_bram_we_o), .out_bram_addr_o(out_bram_addr_o), .out_bram_din_o(out_bram_din_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs[127:0], exp[127:0]);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int t, input int m, input int w);
    logic [63:0] x;
    x = {16'hA5C3, 8'(t), 8'(m), 32'(w)};
    return {16{x}};
  endfunction

  task automatic push(input int idx, input int addr, input logic [DW-1:0] data);
    wr_t e;
    e.idx = idx; e.addr = BW'(addr); e.data = data;
    exp_q.push_back(e);
  endtask

  // Every BRAM write the DUT emits must match the head of the scoreboard.
  always @(negedge clk_i) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (out_bram_we_o[i]) begin
          chk("wr_expected", DW'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_idx", i, e.idx);
            chk("wr_addr", out_bram_addr_o[i*BW +: BW], e.addr);
            chk("wr_data", out_bram_din_o[i*DW +: DW], e.data);
          end
        end
      end
    end
  end

  task automatic start_fill(input logic sel, input logic [31:0] a0, a1, l0, l1);
    @(negedge clk_i);
    start_i = 1'b1; bank_sel_i = sel;
    mat_addr_i = {a1, a0}; mat_len_i = {l1, l0};
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  // Accept one AR (optionally stalling), then return `beats` R beats ending in rlast.
  task automatic serve(input int t, input int bank, input int m, input logic [31:0] ea,
                       input int beats, input int word0, input int hold,
                       input bit gaps, input bit ctl, input bit poke);
    int n = 0;
    while (!mig_arvalid_o && n < 100) begin @(negedge clk_i); n++; end
    chk("ar_seen", DW'(mig_arvalid_o), 1);
    chk("ar_addr", mig_addr_o, ea);
    chk("ar_len", mig_arlen_o, beats - 1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk_i);
      chk("ar_hold_valid", DW'(mig_arvalid_o), 1);
      chk("ar_hold_addr", mig_addr_o, ea);
      chk("ar_hold_len", mig_arlen_o, beats - 1);
    end
    mig_arready_i = 1'b1;
    @(negedge clk_i);
    mig_arready_i = 1'b0;
    chk("r_ready", DW'(mig_rready_o), 1);
    chk("ar_drop", DW'(mig_arvalid_o), 0);
    for (int b = 0; b < beats; b++) begin
      if (gaps && (b % 2 == 1)) begin
        mig_rvalid_i = 1'b0; mig_rdata_i = pat(99, 9, b); ctl_bram_we_i = 2'b00;
        if (poke) begin start_i = 1'b1; bank_sel_i = 1'b1; mat_len_i = {32'd7, 32'd7}; end
        @(negedge clk_i);
        start_i = 1'b0;
      end
      mig_rvalid_i = 1'b1;
      mig_rlast_i  = (b == beats - 1);
      mig_rdata_i  = pat(t, m, word0 + b);
      if (ctl) begin
        ctl_bram_we_i   = 2'b11;
        ctl_bram_addr_i = {BW'(5), BW'(5)};
        ctl_bram_din_i  = {pat(9, 1, b), pat(9, 0, b)};
        push(0, 5, pat(9, 0, b));
        push(1, 5, pat(9, 1, b));
      end
      push(bank * 2 + m, word0 + b, pat(t, m, word0 + b));
      @(negedge clk_i);
    end
    mig_rvalid_i = 1'b0; mig_rlast_i = 1'b0; ctl_bram_we_i = 2'b00;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!done_o && n < bound) begin
      chk("no_ar", DW'(mig_arvalid_o), 0);
      @(negedge clk_i); n++;
    end
    chk("done_seen", DW'(done_o), 1);
    @(negedge clk_i);
    chk("done_pulse", DW'(done_o), 0);
    chk("idle_busy", DW'(busy_o), 0);
    chk("q_drain", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start_i = 1'b0; bank_sel_i = 1'b0; mat_addr_i = '0; mat_len_i = '0;
    mig_arready_i = 1'b0; mig_rdata_i = '0; mig_rvalid_i = 1'b0; mig_rlast_i = 1'b0;
    ctl_bram_we_i = '0; ctl_bram_addr_i = '0; ctl_bram_din_i = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_busy", DW'(busy_o), 0);
    chk("rst_done", DW'(done_o), 0);
    chk("rst_err", DW'(err_o), 0);
    chk("rst_arvalid", DW'(mig_arvalid_o), 0);
    chk("rst_rready", DW'(mig_rready_o), 0);
    chk("rst_we", out_bram_we_o, 0);
    rst_n = 1'b1;

    // 1: two short matrices into bank 0, done two cycles after the last beat
    start_fill(1'b0, 32'h1000, 32'h8000, 32'd4, 32'd3);
    chk("t1_busy", DW'(busy_o), 1);
    serve(1, 0, 0, 32'h1000, 4, 0, 0, 0, 0, 0);
    serve(1, 0, 1, 32'h8000, 3, 0, 0, 0, 0, 0);
    chk("t1_done_early", DW'(done_o), 0);
    @(negedge clk_i);
    chk("t1_done", DW'(done_o), 1);
    chk("t1_busy_done", DW'(busy_o), 1);
    @(negedge clk_i);
    chk("t1_done_end", DW'(done_o), 0);
    chk("t1_idle", DW'(busy_o), 0);
    chk("t1_drain", exp_q.size(), 0);

    // 2: 600 beats split into 256/256/88, empty matrix 1 skipped
    start_fill(1'b0, 32'h0010_0000, 32'h0020_0000, 32'd600, 32'd0);
    serve(2, 0, 0, 32'h0010_0000, 256, 0,   0, 0, 0, 0);
    serve(2, 0, 0, 32'h0010_8000, 256, 256, 0, 0, 0, 0);
    serve(2, 0, 0, 32'h0011_0000, 88,  512, 0, 0, 0, 0);
    wait_done(20);

    // 3: fill bank 1 while the controller writes bank 0 at address 5
    start_fill(1'b1, 32'h2000, 32'h3000, 32'd3, 32'd2);
    serve(3, 1, 0, 32'h2000, 3, 0, 0, 0, 1, 0);
    serve(3, 1, 1, 32'h3000, 2, 0, 0, 0, 1, 0);
    wait_done(20);

    // 4: over-depth length rejected without MIG traffic
    start_fill(1'b0, 32'h5000, 32'h6000, 32'd1025, 32'd2);
    chk("t4_busy", DW'(busy_o), 1);
    chk("t4_arvalid", DW'(mig_arvalid_o), 0);
    @(negedge clk_i);
    chk("t4_done", DW'(done_o), 1);
    chk("t4_err", DW'(err_o), 1);
    chk("t4_idle", DW'(busy_o), 0);
    chk("t4_arvalid2", DW'(mig_arvalid_o), 0);
    @(negedge clk_i);
    chk("t4_done_end", DW'(done_o), 0);
    chk("t4_err_sticky", DW'(err_o), 1);

    // 5: AR stall, R gaps and an ignored start mid-fill; err clears on accept
    start_fill(1'b0, 32'h4000, 32'h9000, 32'd5, 32'd0);
    chk("t5_err_clr", DW'(err_o), 0);
    serve(5, 0, 0, 32'h4000, 5, 0, 10, 1, 0, 1);
    wait_done(20);

    // 6: async reset in the middle of a burst, then a clean fill
    start_fill(1'b0, 32'h7000, 32'hA000, 32'd8, 32'd0);
    begin
      int n = 0;
      while (!mig_arvalid_o && n < 100) begin @(negedge clk_i); n++; end
    end
    chk("t6_ar", mig_addr_o, 32'h7000);
    mig_arready_i = 1'b1;
    @(negedge clk_i);
    mig_arready_i = 1'b0;
    for (int b = 0; b < 3; b++) begin
      mig_rvalid_i = 1'b1; mig_rdata_i = pat(6, 0, b);
      push(0, b, pat(6, 0, b));
      @(negedge clk_i);
    end
    mig_rvalid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy", DW'(busy_o), 0);
    chk("t6_rready", DW'(mig_rready_o), 0);
    chk("t6_arvalid", DW'(mig_arvalid_o), 0);
    chk("t6_we", out_bram_we_o, 0);
    chk("t6_addr", out_bram_addr_o, 0);
    chk("t6_drain", exp_q.size(), 0);
    @(negedge clk_i);
    rst_n = 1'b1;
    start_fill(1'b0, 32'hB000, 32'hC000, 32'd2, 32'd1);
    serve(7, 0, 0, 32'hB000, 2, 0, 0, 0, 0, 0);
    serve(7, 0, 1, 32'hC000, 1, 0, 0, 0, 0, 0);
    wait_done(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spad_prefetch_arbiter.md
Name: spad_prefetch_arbiter

Overview:
Parametrised successor to the two-matrix scratchpad fill arbiter. Streams NUM_MAT operand matrices from the MIG read channel into one bank of a ping-pong scratchpad, with one BRAM per matrix per bank. The accelerator controller owns the other bank through a registered mux. Matrices longer than one burst are split into MAX_BURST-beat bursts. Zero-length matrices are skipped, and over-depth lengths are rejected.

Parameters:
ADDR_WIDTH, 32, MIG byte-address width
DATA_WIDTH, 1024, MIG beat / BRAM word width (bits)
REG_WIDTH, 32, length register width
NUM_MAT, 2, matrices (channels) per fill, 1..8
MAX_BURST, 256, max beats per MIG burst, 1..256
BANK_DEPTH, 1024, words per BRAM; BANK_AW = $clog2(BANK_DEPTH)

Ports:
clk_i  in  1  clock
rst_n  in  1  async active-low reset
start_i  in  1  fill request pulse; ignored while busy_o=1
bank_sel_i  in  1  bank to fill (0/1), latched on accepted start_i
mat_addr_i  in  NUM_MAT*ADDR_WIDTH  per-matrix MIG base byte address, latched on start
mat_len_i  in  NUM_MAT*REG_WIDTH  per-matrix length in beats, latched on start
busy_o  out  1  fill in progress
done_o  out  1  one-cycle pulse, fill complete
err_o  out  1  sticky; some len > BANK_DEPTH; cleared by next accepted start
mig_addr_o  out  ADDR_WIDTH  AR address
mig_arvalid_o  out  1  AR valid
mig_arlen_o  out  8  beats-1
mig_arready_i  in  1  AR ready
mig_rdata_i  in  DATA_WIDTH  R data
mig_rvalid_i  in  1  R valid
mig_rlast_i  in  1  R last
mig_rready_o  out  1  R ready
ctl_bram_we_i  in  NUM_MAT  controller write enables (controller bank)
ctl_bram_addr_i  in  NUM_MAT*BANK_AW  controller addresses
ctl_bram_din_i  in  NUM_MAT*DATA_WIDTH  controller write data
out_bram_we_o  out  2*NUM_MAT  index b*NUM_MAT+m = bank b, matrix m
out_bram_addr_o  out  2*NUM_MAT*BANK_AW  per-BRAM address
out_bram_din_o  out  2*NUM_MAT*DATA_WIDTH  per-BRAM data

Behaviour:
- Reset (async, any state): FSM=IDLE; all outputs 0; latched regs 0; in-flight burst abandoned (MIG drained by system reset).
- FSM: IDLE -> CHECK on start_i && !busy_o. CHECK: if any len > BANK_DEPTH, set err_o, pulse done_o, go to IDLE (no MIG traffic). Else m=0, go to SEL.
- SEL: if m==NUM_MAT, go to DONE. If len[m]==0, m++ and stay in SEL (one cycle per skip). Else rem=len[m], addr=base[m], word=0, go to REQ.
- REQ: mig_arvalid_o=1, mig_addr_o=addr, mig_arlen_o=min(rem,MAX_BURST)-1. Hold stable until mig_arready_i, then go to DATA. AR and R never overlap.
- DATA: mig_rready_o=1. Each rvalid beat writes mig_rdata_i into fill-bank BRAM m at address word, then word++ and rem--. On rlast: if rem (after decrement) ==0, m++ and go to SEL; else addr += MAX_BURST*DATA_WIDTH/8 and go to REQ.
- DONE: done_o=1 for one cycle, then IDLE. busy_o=1 in every state except IDLE.
- BRAM mux (registered, 1-cycle latency for all paths):
  - Fill bank (latched sel): we only for the active matrix during a valid beat; all its BRAMs get addr=word, din=rdata.
  - Other bank: passes ctl_* for each matrix.
  - In IDLE, both banks pass ctl_* (fill bank included).
- mig_arlen_o is 8 bits. rem and word widths: REG_WIDTH and BANK_AW+1.
- Beat count vs rlast mismatch is not checked. Fill is always governed by rlast.

Test Plan:
- NUM_MAT=2, len={4,3}, base={0x1000,0x8000}, sel=0 -> AR(0x1000,arlen=3), AR(0x8000,arlen=2); bank0 BRAM0 addr0..3, BRAM1 addr0..2 written; done_o after last beat +2 cycles.
- len={600,0}, MAX_BURST=256 -> ARs at base, +0x8000, +0x10000 with arlen 255,255,87; BRAM0 addr 0..599; matrix1 skipped; no AR for matrix1.
- sel=1 fill while ctl_bram_we_i=2'b11, addr=5 -> bank0 BRAMs written at 5 with ctl data 1 cycle later; bank1 only by MIG data.
- len={1025,2}, BANK_DEPTH=1024 -> err_o=1, done_o pulse, zero AR; next valid start clears err_o.
- arready held low 10 cycles then rvalid gaps -> addr/arlen stable, only valid beats written; start_i pulsed mid-fill ignored.
- rst_n asserted mid-DATA -> outputs 0 immediately (async), FSM IDLE, new start runs a clean fill.
